cmult_sched: RTL and testbench
==============================

Name: cmult_sched

Overview:
- Round-robin scheduler that shares one pipelined complex multiplier (25x18 operands, 48-bit products, fixed pipeline latency, no enable) between N_REQ requesters.
- Accepts operand pairs via valid/ready, issues at most one per cycle, and tracks each issue with an ID pipeline aligned to the multiplier latency.
- Routes each product back, tagged with the requester ID.
- Sits between the DSP48E complex-multiply datapath and its client channels.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, equal to clog2(N_REQ)
- MULT_LATENCY, 4, cycles from multiplier input registered to product valid on M_PROD_*

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ_VALID  in  N_REQ  per-requester operand valid
- REQ_READY  out  N_REQ  per-requester grant; combinational, one-hot or zero
- REQ_A_REAL  in  N_REQ*25  flattened; requester k occupies bits [25k+24:25k]
- REQ_A_IMAG  in  N_REQ*25  same layout as REQ_A_REAL
- REQ_B_REAL  in  N_REQ*18  flattened, 18 bits per requester
- REQ_B_IMAG  in  N_REQ*18  flattened, 18 bits per requester
- HOLD  in  1  stop issuing and drain the multiplier
- M_A_REAL  out  25  registered operand to multiplier
- M_A_IMAG  out  25  registered operand to multiplier
- M_B_REAL  out  18  registered operand to multiplier
- M_B_IMAG  out  18  registered operand to multiplier
- M_PROD_REAL  in  48  product real part from multiplier
- M_PROD_IMAG  in  48  product imaginary part from multiplier
- RES_VALID  out  1  result strobe, one cycle per accepted request
- RES_ID  out  ID_W  requester that owns the result
- RES_REAL  out  48  registered product real part
- RES_IMAG  out  48  registered product imaginary part
- BUSY  out  1  at least one request in flight
- HALTED  out  1  HOLD asserted and pipeline empty

Behaviour:
- Reset: all registered outputs 0; FSM=RUN; RR pointer=N_REQ-1, so requester 0 has first priority; tag pipeline cleared.
- Reset mid-operation discards in-flight results; no RES_VALID is produced for them.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when HOLD=1.
  - DRAIN -> HALTED when the in-flight count is 0.
  - DRAIN or HALTED -> RUN when HOLD=0.
- Grant rule: only in RUN with HOLD=0. Search from pointer+1 with wrap, take the first requester with REQ_VALID. REQ_READY[g]=1 in that same cycle.
- The transfer happens when REQ_VALID[g] and REQ_READY[g] are both high. On that edge the pointer moves to g.
- A requester that holds VALID low gets no ready; ready never depends on that requester's own ready.
- Issue: on the transfer edge, M_A_*/M_B_* capture requester g's operands, and tag {valid=1, id=g} enters the tag shift register (depth MULT_LATENCY+1).
- Cycles with no issue hold M_* unchanged and push tag valid=0.
- Latency: handshake in cycle 0 -> RES_VALID=1 in cycle MULT_LATENCY+2, with RES_ID=g.
- RES_REAL/RES_IMAG are registered copies of M_PROD_*. They are updated only when the tag is valid and hold otherwise.
- Throughput is one issue per cycle. Results leave in issue order; there is no back-pressure on RES_*.
- In-flight count: +1 on issue, -1 on RES_VALID. Both in one cycle leaves it unchanged.
  - BUSY = (count != 0).
  - HALTED = (state == HALTED).
- Products are (Ar*Br - Ai*Bi) and (Ar*Bi + Ai*Br), formed by the multiplier. The scheduler does no arithmetic and no truncation.
- HOLD rising while a request is valid: no grant in that cycle. HOLD falling: grant is possible in the first RUN cycle.

Optional Feature:
- Macro: CMULT_SCHED_STATS_EN.
- Defined: adds input STATS_CLR (1 bit) and output GRANT_CNT (N_REQ*16, flattened).
  - Each requester has a 16-bit counter that increments per accepted request and saturates at 0xFFFF.
  - STATS_CLR zeroes all counters synchronously and has priority over an increment in the same cycle.
  - Counters reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package cmult_sched_pkg holds:
  - width constants A_W=25, B_W=18, P_W=48, STAT_W=16
  - FSM state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2)
- Sub-module cmult_rr_arbiter: N_REQ-wide round-robin grant with pointer register, enable input, one-hot grant and encoded ID output.

Test Plan (MULT_LATENCY=4, N_REQ=4, a behavioural multiplier model of matching latency):
- Single request: req0 A=2+j2, B=6+j2 -> RES_VALID 6 cycles after handshake, RES_ID=0, RES_REAL=8, RES_IMAG=16.
- Large values: req1 A=2020+j2000, B=2020+j2020 -> RES_REAL=40400 (0x9DD0), RES_IMAG=8120400 (0x7BE850), RES_ID=1.
- Contention: all four VALID high continuously -> grants 0,1,2,3,0,... on consecutive cycles; RES_ID follows the same order back-to-back with no gaps.
- HOLD: assert HOLD after 3 issues -> REQ_READY=0 from that cycle; 3 results delivered; HALTED=1 one cycle after the last RES_VALID, BUSY=0; release HOLD -> the grant resumes at the next RR requester.
- Reset mid-flight: pulse RST_N low with 3 requests in flight -> outputs 0, no stale RES_VALID afterwards, requester 0 granted first after reset.
- With CMULT_SCHED_STATS_EN: 70000 grants to req2 -> GRANT_CNT[2]=0xFFFF; STATS_CLR -> 0.

Source files
------------

// File: rtl/cmult_sched_pkg.sv
// cmult_sched_pkg: shared widths and FSM encoding for the complex-multiplier scheduler.
package cmult_sched_pkg;
  localparam int A_W = 25;
  localparam int B_W = 18;
  localparam int P_W = 48;
  localparam int STAT_W = 16;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;
endpackage

// File: rtl/cmult_sched_if.sv
// cmult_sched_if: requester, multiplier and result channels of the scheduler.
interface cmult_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
);
  import cmult_sched_pkg::*;
  logic [N_REQ-1:0] req_valid_i;
  logic [N_REQ-1:0] req_ready_o;
  logic [N_REQ*A_W-1:0] req_a_real_i;
  logic [N_REQ*A_W-1:0] req_a_imag_i;
  logic [N_REQ*B_W-1:0] req_b_real_i;
  logic [N_REQ*B_W-1:0] req_b_imag_i;
  logic hold_i;
  logic [A_W-1:0] m_a_real_o;
  logic [A_W-1:0] m_a_imag_o;
  logic [B_W-1:0] m_b_real_o;
  logic [B_W-1:0] m_b_imag_o;
  logic [P_W-1:0] m_prod_real_i;
  logic [P_W-1:0] m_prod_imag_i;
  logic res_valid_o;
  logic [ID_W-1:0] res_id_o;
  logic [P_W-1:0] res_real_o;
  logic [P_W-1:0] res_imag_o;
  logic busy_o;
  logic halted_o;
  modport master (
    input  req_valid_i, req_a_real_i, req_a_imag_i, req_b_real_i, req_b_imag_i,
           hold_i, m_prod_real_i, m_prod_imag_i,
    output req_ready_o, m_a_real_o, m_a_imag_o, m_b_real_o, m_b_imag_o,
           res_valid_o, res_id_o, res_real_o, res_imag_o, busy_o, halted_o
  );
  modport slave (
    output req_valid_i, req_a_real_i, req_a_imag_i, req_b_real_i, req_b_imag_i,
           hold_i, m_prod_real_i, m_prod_imag_i,
    input  req_ready_o, m_a_real_o, m_a_imag_o, m_b_real_o, m_b_imag_o,
           res_valid_o, res_id_o, res_real_o, res_imag_o, busy_o, halted_o
  );
endinterface

// File: rtl/cmult_rr_arbiter.sv
// cmult_rr_arbiter: round-robin grant searching from pointer+1; pointer follows the winner.
module cmult_rr_arbiter #(
  parameter int N = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] id_o,
  output logic            vld_o
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  function automatic int wrap(input int p);
    return p >= N ? p - N : p;
  endfunction
  always_comb begin
    int k;
    k = 0;
    gnt_o = '0;
    id_o = '0;
    vld_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k = wrap(int'(ptr_q) + i);
      if (en_i && !vld_o && req_i[ID_W'(k)]) begin
        gnt_o[ID_W'(k)] = 1'b1;
        id_o = ID_W'(k);
        vld_o = 1'b1;
      end
    end
    ptr_d = vld_o ? id_o : ptr_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr_q <= ID_W'(N - 1);
    else ptr_q <= ptr_d;
endmodule

// File: rtl/cmult_sched.sv
// cmult_sched: round-robin sharing of one pipelined complex multiplier with ID-tagged results.
// Optional per-requester grant counters when CMULT_SCHED_STATS_EN is defined.
module cmult_sched
  import cmult_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ),
  parameter int MULT_LATENCY = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef CMULT_SCHED_STATS_EN
  input  logic stats_clr_i,
  output logic [N_REQ*STAT_W-1:0] grant_cnt_o,
`endif
  cmult_sched_if.master bus
);
  localparam int L = MULT_LATENCY;
  localparam int CNT_W = $clog2(L + 3);
  state_e state_q, state_d;
  logic grant_en, fire;
  logic [ID_W-1:0] gid;
  logic [N_REQ-1:0] gnt;
  logic [A_W-1:0] m_ar_q, m_ai_q;
  logic [B_W-1:0] m_br_q, m_bi_q;
  logic [L:0] tv_q;
  logic [L:0][ID_W-1:0] tid_q;
  logic res_v_q;
  logic [ID_W-1:0] res_id_q;
  logic [P_W-1:0] res_re_q, res_im_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmult_rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .en_i(grant_en),
    .req_i(bus.req_valid_i),
    .gnt_o(gnt),
    .id_o(gid),
    .vld_o(fire)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= RUN;
    else state_q <= state_d;
  // next count is used so HALTED rises the cycle right after the final result
  always_comb
    state_d = state_q == RUN ? (bus.hold_i ? DRAIN : RUN) :
              !bus.hold_i ? RUN :
              cnt_d == '0 ? HALTED : state_q;
  always_comb begin
    grant_en = state_q == RUN && !bus.hold_i;
    bus.halted_o = state_q == HALTED;
  end
  assign cnt_d = cnt_q + CNT_W'(fire) - CNT_W'(res_v_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      m_ar_q <= '0;
      m_ai_q <= '0;
      m_br_q <= '0;
      m_bi_q <= '0;
      tv_q <= '0;
      tid_q <= '0;
      res_v_q <= 1'b0;
      res_id_q <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      cnt_q <= '0;
    end else begin
      if (fire) begin
        m_ar_q <= bus.req_a_real_i[gid*A_W +: A_W];
        m_ai_q <= bus.req_a_imag_i[gid*A_W +: A_W];
        m_br_q <= bus.req_b_real_i[gid*B_W +: B_W];
        m_bi_q <= bus.req_b_imag_i[gid*B_W +: B_W];
      end
      tv_q <= {tv_q[L-1:0], fire};
      tid_q <= {tid_q[L-1:0], gid};
      res_v_q <= tv_q[L];
      if (tv_q[L]) begin
        res_id_q <= tid_q[L];
        res_re_q <= bus.m_prod_real_i;
        res_im_q <= bus.m_prod_imag_i;
      end
      cnt_q <= cnt_d;
    end
  assign bus.req_ready_o = gnt;
  assign bus.m_a_real_o = m_ar_q;
  assign bus.m_a_imag_o = m_ai_q;
  assign bus.m_b_real_o = m_br_q;
  assign bus.m_b_imag_o = m_bi_q;
  assign bus.res_valid_o = res_v_q;
  assign bus.res_id_o = res_id_q;
  assign bus.res_real_o = res_re_q;
  assign bus.res_imag_o = res_im_q;
  assign bus.busy_o = cnt_q != '0;
`ifdef CMULT_SCHED_STATS_EN
  logic [N_REQ-1:0][STAT_W-1:0] gcnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) gcnt_q <= '0;
    else
      for (int k = 0; k < N_REQ; k++)
        gcnt_q[k] <= stats_clr_i ? '0 :
                     (gnt[k] && gcnt_q[k] != '1) ? gcnt_q[k] + 1'b1 : gcnt_q[k];
  assign grant_cnt_o = gcnt_q;
`endif
endmodule

// File: tb/tb_cmult_sched.sv
// tb_cmult_sched: directed checks of cmult_sched with a 4-cycle behavioural complex multiplier.
module tb_cmult_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cmult_sched_if #(.N_REQ(4), .ID_W(2)) bus ();
`ifdef CMULT_SCHED_STATS_EN
  logic stats_clr = 1'b0;
  logic [63:0] grant_cnt;
`endif
  cmult_sched #(.N_REQ(4), .ID_W(2), .MULT_LATENCY(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
`ifdef CMULT_SCHED_STATS_EN
    .stats_clr_i(stats_clr),
    .grant_cnt_o(grant_cnt),
`endif
    .bus(bus)
  );
  logic signed [47:0] p_re [4];
  logic signed [47:0] p_im [4];
  always @(posedge clk) begin
    p_re[0] <= 48'($signed(bus.m_a_real_o)) * 48'($signed(bus.m_b_real_o))
             - 48'($signed(bus.m_a_imag_o)) * 48'($signed(bus.m_b_imag_o));
    p_im[0] <= 48'($signed(bus.m_a_real_o)) * 48'($signed(bus.m_b_imag_o))
             + 48'($signed(bus.m_a_imag_o)) * 48'($signed(bus.m_b_real_o));
    for (int i = 1; i < 4; i++) begin
      p_re[i] <= p_re[i-1];
      p_im[i] <= p_im[i-1];
    end
  end
  assign bus.m_prod_real_i = p_re[3];
  assign bus.m_prod_imag_i = p_im[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_ops(input int k, input int ar, input int ai, input int br, input int bi);
    logic [24:0] a_r, a_i;
    logic [17:0] b_r, b_i;
    a_r = 25'(ar);
    a_i = 25'(ai);
    b_r = 18'(br);
    b_i = 18'(bi);
    bus.req_a_real_i[k*25 +: 25] = a_r;
    bus.req_a_imag_i[k*25 +: 25] = a_i;
    bus.req_b_real_i[k*18 +: 18] = b_r;
    bus.req_b_imag_i[k*18 +: 18] = b_i;
  endtask

  task automatic test_reset();
    bus.req_valid_i = '0;
    bus.hold_i = 1'b0;
    bus.req_a_real_i = '0;
    bus.req_a_imag_i = '0;
    bus.req_b_real_i = '0;
    bus.req_b_imag_i = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.res_valid_o !== 1'b0 || bus.res_real_o !== 48'd0 || bus.res_imag_o !== 48'd0 || bus.res_id_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_res: valid=%b id=%0d re=%0d im=%0d, want all 0", bus.res_valid_o, bus.res_id_o, bus.res_real_o, bus.res_imag_o);
    end
    checks++;
    if (bus.m_a_real_o !== 25'd0 || bus.m_b_imag_o !== 18'd0 || bus.busy_o !== 1'b0 || bus.halted_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_misc: m_a_re=%0d m_b_im=%0d busy=%b halted=%b, want 0", bus.m_a_real_o, bus.m_b_imag_o, bus.busy_o, bus.halted_o);
    end
    tick();
    rst_n = 1'b1;
    bus.req_valid_i = 4'hF;
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: ready=%b want 0001", bus.req_ready_o);
    end
    bus.req_valid_i = '0;
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL no_valid_no_ready: ready=%b want 0000", bus.req_ready_o);
    end
    tick();
  endtask

  task automatic test_single(input string nm, input int k, input int ar, input int ai, input int br, input int bi,
                             input logic [47:0] exp_re, input logic [47:0] exp_im);
    logic early;
    logic [3:0] want;
    want = 4'b0001 << k;
    set_ops(k, ar, ai, br, bi);
    bus.req_valid_i = want;
    #1;
    checks++;
    if (bus.req_ready_o !== want) begin
      errors++;
      $display("FAIL %s_ready: ready=%b want %b", nm, bus.req_ready_o, want);
    end
    tick();
    bus.req_valid_i = '0;
    checks++;
    if (bus.m_a_real_o !== 25'(ar) || bus.m_b_real_o !== 18'(br) || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_issue: m_a_re=%0d m_b_re=%0d busy=%b want %0d %0d 1", nm, bus.m_a_real_o, bus.m_b_real_o, bus.busy_o, ar, br);
    end
    early = 1'b0;
    for (int c = 1; c < 6; c++) begin
      early |= bus.res_valid_o;
      tick();
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: res_valid seen before cycle 6, want none", nm);
    end
    checks++;
    if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 2'(k) || bus.res_real_o !== exp_re || bus.res_imag_o !== exp_im) begin
      errors++;
      $display("FAIL %s_result: valid=%b id=%0d re=%0d im=%0d want 1 %0d %0d %0d", nm,
               bus.res_valid_o, bus.res_id_o, bus.res_real_o, bus.res_imag_o, k, exp_re, exp_im);
    end
    tick();
    checks++;
    if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.res_real_o !== exp_re) begin
      errors++;
      $display("FAIL %s_after: valid=%b busy=%b re=%0d want 0 0 %0d", nm, bus.res_valid_o, bus.busy_o, bus.res_real_o, exp_re);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] er [4];
    logic [47:0] ei [4];
    er = '{48'd1, 48'd4, 48'd7, 48'd10};
    ei = '{48'd5, 48'd7, 48'd9, 48'd11};
    do_reset();
    for (int k = 0; k < 4; k++) set_ops(k, k + 1, 1, 3, 2);
    for (int c = 0; c < 15; c++) begin
      bus.req_valid_i = c < 8 ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        checks++;
        if (bus.req_ready_o !== (4'b0001 << (c % 4))) begin
          errors++;
          $display("FAIL rr_grant c=%0d: ready=%b want %b", c, bus.req_ready_o, 4'b0001 << (c % 4));
        end
      end
      if (c >= 6 && c < 14) begin
        checks++;
        if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 2'((c - 6) % 4) ||
            bus.res_real_o !== er[(c - 6) % 4] || bus.res_imag_o !== ei[(c - 6) % 4]) begin
          errors++;
          $display("FAIL rr_result c=%0d: valid=%b id=%0d re=%0d im=%0d want 1 %0d %0d %0d", c,
                   bus.res_valid_o, bus.res_id_o, bus.res_real_o, bus.res_imag_o,
                   (c - 6) % 4, er[(c - 6) % 4], ei[(c - 6) % 4]);
        end
      end
      if (c == 14) begin
        checks++;
        if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
          errors++;
          $display("FAIL rr_drained: valid=%b busy=%b want 0 0", bus.res_valid_o, bus.busy_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [3:0] want;
    for (int c = 0; c < 12; c++) begin
      bus.req_valid_i = 4'hF;
      bus.hold_i = c >= 3 && c < 10;
      #1;
      want = c < 3 ? (4'b0001 << c) : c == 11 ? 4'b1000 : 4'b0000;
      checks++;
      if (bus.req_ready_o !== want) begin
        errors++;
        $display("FAIL hold_ready c=%0d: ready=%b want %b", c, bus.req_ready_o, want);
      end
      checks++;
      if (bus.res_valid_o !== (c >= 6 && c <= 8) || (c >= 6 && c <= 8 && bus.res_id_o !== 2'(c - 6))) begin
        errors++;
        $display("FAIL hold_result c=%0d: valid=%b id=%0d", c, bus.res_valid_o, bus.res_id_o);
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (bus.halted_o !== (c == 9) || bus.busy_o !== (c == 8)) begin
          errors++;
          $display("FAIL hold_halted c=%0d: halted=%b busy=%b want %b %b", c, bus.halted_o, bus.busy_o, c == 9, c == 8);
        end
      end
      tick();
    end
    bus.req_valid_i = '0;
    bus.hold_i = 1'b0;
    for (int c = 12; c < 19; c++) begin
      if (c == 17) begin
        checks++;
        if (bus.res_valid_o !== 1'b1 || bus.res_id_o !== 2'd3) begin
          errors++;
          $display("FAIL hold_resume_result: valid=%b id=%0d want 1 3", bus.res_valid_o, bus.res_id_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    logic stale;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid_i = 4'hF;
      tick();
    end
    bus.req_valid_i = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.m_a_real_o !== 25'd0 || bus.res_real_o !== 48'd0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b busy=%b m_a_re=%0d re=%0d want 0", bus.res_valid_o, bus.busy_o, bus.m_a_real_o, bus.res_real_o);
    end
    tick();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 10; c++) begin
      stale |= bus.res_valid_o;
      tick();
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: res_valid seen after reset, want none");
    end
    bus.req_valid_i = 4'hF;
    #1;
    checks++;
    if (bus.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_first_grant: ready=%b want 0001", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = '0;
    for (int c = 0; c < 8; c++) tick();
  endtask

`ifdef CMULT_SCHED_STATS_EN
  task automatic test_stats();
    logic [15:0] g;
    do_reset();
    bus.req_valid_i = 4'b0100;
    for (int c = 0; c < 5; c++) tick();
    g = grant_cnt[32 +: 16];
    checks++;
    if (g !== 16'd5) begin
      errors++;
      $display("FAIL stats_count: cnt2=%0d want 5", g);
    end
    for (int c = 5; c < 70000; c++) tick();
    g = grant_cnt[32 +: 16];
    checks++;
    if (g !== 16'hFFFF || grant_cnt[15:0] !== 16'd0) begin
      errors++;
      $display("FAIL stats_sat: cnt2=%h cnt0=%h want ffff 0000", g, grant_cnt[15:0]);
    end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    bus.req_valid_i = '0;
    g = grant_cnt[32 +: 16];
    checks++;
    if (g !== 16'd0) begin
      errors++;
      $display("FAIL stats_clr: cnt2=%h want 0000", g);
    end
    for (int c = 0; c < 8; c++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single("single", 0, 2, 2, 6, 2, 48'd8, 48'd16);
    test_single("large", 1, 2020, 2000, 2020, 2020, 48'h9DD0, 48'h7BE850);
    test_back_to_back();
    test_hold();
    test_reset_midflight();
`ifdef CMULT_SCHED_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
